wshbn_intercon: RTL and testbench

Parametrised Wishbone shared-bus interconnect: arbitrates between NUM_MASTERS bus masters (e.g. CPU peripheral master, cache-line master, DMA) and decodes the address onto NUM_SLAVES peripheral slaves (PIO, timer, UART, SPI, RAM). It replaces ad-hoc per-top-level strobe decode and read-data muxing. It adds round-robin arbitration with cycle locking, an ERR response for unmapped addresses, and a watchdog that terminates stalled cycles.

---
 rtl/wshbn_intercon.sv | 178 +++++++++++++++++
 tb/tb_wshbn_intercon.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wshbn_intercon.sv
// Shared-bus Wishbone interconnect: round-robin arbitration with cycle locking,
// one-hot slave decode, ERR for unmapped addresses and a stalled-cycle watchdog.
module wshbn_intercon #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 4,
  parameter int AW          = 8,
  parameter int DW          = 32,
  parameter int SEL_LSB     = 4,
  parameter int SEL_W       = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                      CLK_I,
  input  logic                      RST_I,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
  output logic [DW-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic                      s_cyc_o,
  output logic [NUM_SLAVES-1:0]     s_stb_o,
  output logic                      s_we_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  input  logic [NUM_SLAVES*DW-1:0]  s_dat_i,
  input  logic [NUM_SLAVES-1:0]     s_ack_i,
  output logic [NUM_MASTERS-1:0]    gnt_o,
  output logic                      timeout_o,
  output logic                      dbg_state
);

  // Handshake: a beat is offered while the owner's STB is high and completes in
  // the cycle where ACK or ERR is high; the master holds STB and its fields until then.

  localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [OW-1:0] owner, owner_nxt;
  logic [OW-1:0] last_owner, last_owner_nxt;
  logic [CW-1:0] wdog, wdog_nxt;

  logic          found;
  logic [OW-1:0] grant_idx;
  int            cand;

  logic          own_cyc, own_stb, own_we;
  logic [AW-1:0] own_adr;
  logic [DW-1:0] own_dat;
  logic [SEL_W-1:0] sel_idx;
  logic          mapped;
  logic          sel_ack;
  logic [DW-1:0] sel_dat;
  logic          busy;
  logic          fire;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(NUM_MASTERS - 1);
      wdog       <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      wdog       <= wdog_nxt;
    end
  end

  // Round-robin search starting just above the previous owner, wrapping around.
  always_comb begin
    found     = 1'b0;
    grant_idx = last_owner;
    cand      = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = int'(last_owner) + i;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!found && (j == cand) && m_cyc_i[j]) begin
          found     = 1'b1;
          grant_idx = OW'(j);
        end
      end
    end
  end

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (OW'(j) == owner) begin
        own_cyc = m_cyc_i[j];
        own_stb = m_stb_i[j];
        own_we  = m_we_i[j];
        own_adr = m_adr_i[j*AW +: AW];
        own_dat = m_dat_i[j*DW +: DW];
      end
    end
  end

  assign sel_idx = own_adr[SEL_LSB +: SEL_W];
  assign mapped  = (int'(sel_idx) < NUM_SLAVES);

  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (int'(sel_idx) == k) begin
        sel_ack = s_ack_i[k];
        sel_dat = s_dat_i[k*DW +: DW];
      end
    end
  end

  assign busy = (state == BUSY);
  assign fire = (TIMEOUT > 0) && busy && own_stb && mapped && (wdog == TO_VAL);

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt      = BUSY;
          owner_nxt      = grant_idx;
          last_owner_nxt = grant_idx;
        end
      end
      BUSY: begin
        if (!own_cyc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The count only runs while a mapped beat is stalled; firing clears it.
  always_comb begin
    wdog_nxt = '0;
    if ((TIMEOUT > 0) && busy && own_cyc && own_stb && mapped && !sel_ack && !fire)
      wdog_nxt = wdog + 1'b1;
  end

  always_comb begin
    gnt_o   = '0;
    m_ack_o = '0;
    m_err_o = '0;
    s_stb_o = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (busy && (OW'(j) == owner)) begin
        gnt_o[j]   = 1'b1;
        m_ack_o[j] = mapped && sel_ack && !fire;
        m_err_o[j] = own_stb && (!mapped || fire);
      end
    end
    for (int k = 0; k < NUM_SLAVES; k++) begin
      s_stb_o[k] = busy && own_stb && (int'(sel_idx) == k) && !fire;
    end
  end

  assign s_cyc_o   = busy && own_cyc;
  assign s_we_o    = busy && own_we;
  assign s_adr_o   = busy ? own_adr : '0;
  assign s_dat_o   = busy ? own_dat : '0;
  assign m_dat_o   = (busy && mapped) ? sel_dat : '0;
  assign timeout_o = fire;
  assign dbg_state = state;

endmodule

// File: tb/tb_wshbn_intercon.sv
// Directed bench for wshbn_intercon: responding slave models, master driver task,
// and an expected-response queue checked by an independent monitor.
module tb_wshbn_intercon;

  localparam int W = 35;  // {check_data, err, master, data}

  logic        clk, rst;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [15:0] m_adr;
  logic [63:0] m_dat_w;
  logic [31:0] m_dat_o;
  logic [1:0]  m_ack, m_err;
  logic        s_cyc;
  logic [3:0]  s_stb;
  logic        s_we;
  logic [7:0]  s_adr;
  logic [31:0] s_dat_o;
  logic [127:0] s_dat_i;
  logic [3:0]  s_ack;
  logic [1:0]  gnt;
  logic        timeout;
  logic        dbg_state;

  logic [W-1:0] exp_q[$];
  logic [1:0]   gnt_log[$];
  logic [1:0]   gnt_prev;
  int           no_gap;
  logic [3:0]   rsp_stb;
  logic         rsp_to;
  int           total, bad;

  logic [31:0] mem [4][16];
  int          wait_c [4];
  bit          en [4];
  int          cnt [4];

  wshbn_intercon #(
    .NUM_MASTERS(2), .NUM_SLAVES(4), .AW(8), .DW(32),
    .SEL_LSB(4), .SEL_W(4), .TIMEOUT(16)
  ) dut (
    .CLK_I(clk), .RST_I(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat_w),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack),
    .gnt_o(gnt), .timeout_o(timeout), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout act=stalled exp=finish");
    $fatal(1, "simulation stalled");
  end

  // Slave models: ack after wait_c[k] strobed cycles unless disabled.
  always_comb begin
    s_ack   = '0;
    s_dat_i = '0;
    for (int k = 0; k < 4; k++) begin
      s_ack[k] = s_stb[k] && en[k] && (cnt[k] >= wait_c[k]);
      s_dat_i[k*32 +: 32] = mem[k][s_adr[3:0]];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (s_stb[k] && !s_ack[k]) cnt[k] <= cnt[k] + 1;
      else cnt[k] <= 0;
      if (s_stb[k] && s_we && s_ack[k]) mem[k][s_adr[3:0]] <= s_dat_o;
    end
  end

  function automatic logic [W-1:0] mk(input bit chk_d, input bit err, input bit m, input logic [31:0] d);
    return {chk_d, err, m, (chk_d ? d : 32'h0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Driver: called just after a rising edge; returns just after the edge that ends the beat.
  task automatic xfer(input int m, input logic we, input logic [7:0] adr, input logic [31:0] dat,
                      input bit keep, output int lat);
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
    m_we[m]  = we;
    m_adr[m*8 +: 8]   = adr;
    m_dat_w[m*32 +: 32] = dat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(m_ack[m] | m_err[m]) && lat < 200);
    if (!(m_ack[m] | m_err[m])) begin
      total++;
      bad++;
      $display("FAIL xfer_wait m=%0d act=no_response exp=ack_or_err", m);
    end
    @(posedge clk);
    #1;
    m_stb[m] = 1'b0;
    m_we[m]  = 1'b0;
    if (!keep) m_cyc[m] = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [1:0]   rsp;
    logic [W-1:0] e, a;
    rsp = m_ack | m_err;
    if (!rst && rsp != 2'b00) begin
      rsp_stb = s_stb;
      rsp_to  = timeout;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected act=ack%b_err%b exp=none", m_ack, m_err);
      end else begin
        e = exp_q.pop_front();
        a = mk(e[W-1], |m_err, rsp[1], m_dat_o);
        if (a !== e || rsp == 2'b11 || (m_ack & m_err) != 2'b00) begin
          bad++;
          $display("FAIL sb_rsp act=%h ack=%b err=%b exp=%h", a, m_ack, m_err, e);
        end
      end
    end
  end

  // Grant history: each new grant, and whether it followed directly on another.
  always @(negedge clk) begin
    if (gnt != 2'b00 && gnt != gnt_prev) begin
      gnt_log.push_back(gnt);
      if (gnt_prev != 2'b00) no_gap++;
    end
    gnt_prev = gnt;
  end

  initial begin
    int lat;
    total = 0; bad = 0; no_gap = 0; gnt_prev = 2'b00;
    rsp_stb = '0; rsp_to = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_w = '0;
    for (int k = 0; k < 4; k++) begin
      wait_c[k] = 0;
      en[k] = 1'b1;
      for (int a = 0; a < 16; a++) mem[k][a] = {8'hA5, 8'(k), 16'(a)};
    end
    mem[0][0] = 32'h11; mem[0][1] = 32'h22; mem[0][2] = 32'h33; mem[0][3] = 32'h44;
    wait_c[1] = 1;
    rst = 1'b1;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_bus", 64'({s_cyc, s_stb, s_we, s_adr, s_dat_o}), 64'h0);
    chk("rst_rsp", 64'({m_ack, m_err, timeout, m_dat_o}), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'h0);
    @(posedge clk); #1; rst = 1'b0;

    // Single write to slave 1 with one wait state
    @(posedge clk); #1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
    m_adr[7:0] = 8'h12; m_dat_w[31:0] = 32'hDEADBEEF;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0));
    @(negedge clk);
    chk("t1_pre_gnt", 64'(gnt), 64'h0);
    @(negedge clk);
    chk("t1_gnt", 64'(gnt), 64'h1);
    chk("t1_stb", 64'(s_stb), 64'h2);
    chk("t1_wdat", 64'(s_dat_o), 64'hDEADBEEF);
    chk("t1_cyc_we_adr", 64'({s_cyc, s_we, s_adr}), 64'h312);
    chk("t1_ack_wait", 64'(m_ack), 64'h0);
    @(negedge clk);
    chk("t1_ack", 64'(m_ack), 64'h1);
    @(posedge clk); #1;
    m_stb[0] = 1'b0; m_cyc[0] = 1'b0; m_we[0] = 1'b0;
    @(negedge clk);
    chk("t1_ack_once", 64'(m_ack), 64'h0);
    @(negedge clk);
    chk("t1_gnt_drop", 64'(gnt), 64'h0);

    // Fresh reset so master 0 wins the first simultaneous arbitration
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    gnt_log.delete(); no_gap = 0;

    // Simultaneous requests, repeated: grants alternate 0,1,0,1
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h11));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'h22));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h11));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'h22));
    fork
      begin
        int l0;
        xfer(0, 1'b0, 8'h00, 32'h0, 1'b0, l0);
        @(posedge clk); #1;
        xfer(0, 1'b0, 8'h00, 32'h0, 1'b0, l0);
      end
      begin
        int l1;
        xfer(1, 1'b0, 8'h01, 32'h0, 1'b0, l1);
        @(posedge clk); #1;
        xfer(1, 1'b0, 8'h01, 32'h0, 1'b0, l1);
      end
    join
    repeat (2) @(negedge clk);
    chk("t2_ngrants", 64'(gnt_log.size()), 64'd4);
    if (gnt_log.size() == 4)
      chk("t2_order", 64'({gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}), 64'b01100110);
    chk("t2_idle_gap", 64'(no_gap), 64'h0);

    // Block transfer by master 0 holds the bus while master 1 waits
    @(posedge clk); #1;
    gnt_log.delete(); no_gap = 0;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h11));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h22));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h33));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h44));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'hDEADBEEF));
    fork
      begin
        int l2;
        xfer(0, 1'b0, 8'h00, 32'h0, 1'b1, l2);
        xfer(0, 1'b0, 8'h01, 32'h0, 1'b1, l2);
        xfer(0, 1'b0, 8'h02, 32'h0, 1'b1, l2);
        xfer(0, 1'b0, 8'h03, 32'h0, 1'b0, l2);
      end
      begin
        int l3;
        xfer(1, 1'b0, 8'h12, 32'h0, 1'b0, l3);
      end
    join
    repeat (2) @(negedge clk);
    chk("t3_ngrants", 64'(gnt_log.size()), 64'd2);
    if (gnt_log.size() == 2)
      chk("t3_order", 64'({gnt_log[0], gnt_log[1]}), 64'b0110);
    chk("t3_idle_gap", 64'(no_gap), 64'h0);

    // Unmapped address: ERR in the first strobed cycle, no slave strobe
    @(posedge clk); #1;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0));
    xfer(0, 1'b0, 8'h50, 32'h0, 1'b0, lat);
    chk("t4_latency", 64'(lat), 64'd2);
    chk("t4_stb", 64'(rsp_stb), 64'h0);
    chk("t4_timeout", 64'(rsp_to), 64'h0);

    // Never-acking slave 2: watchdog fires 16 cycles after the first strobe
    @(posedge clk); #1;
    en[2] = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0));
    xfer(0, 1'b0, 8'h20, 32'h0, 1'b0, lat);
    chk("t5_latency", 64'(lat), 64'd18);
    chk("t5_stb", 64'(rsp_stb), 64'h0);
    chk("t5_timeout", 64'(rsp_to), 64'h1);
    @(negedge clk);
    chk("t5_pulse", 64'(timeout), 64'h0);

    // Reset during a stalled cycle, then master 0 wins first
    @(posedge clk); #1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[15:8] = 8'h20;
    repeat (2) @(negedge clk);
    chk("t6_pre", 64'({gnt, s_cyc, s_stb}), 64'b10_1_0100);
    #2 rst = 1'b1;
    #1 chk("t6_drop", 64'({gnt, s_cyc, s_stb, m_err, m_ack, timeout}), 64'h0);
    m_cyc = '0; m_stb = '0;
    en[2] = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    gnt_log.delete(); no_gap = 0;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h33));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'h44));
    fork
      begin
        int l4;
        xfer(0, 1'b0, 8'h02, 32'h0, 1'b0, l4);
      end
      begin
        int l5;
        xfer(1, 1'b0, 8'h03, 32'h0, 1'b0, l5);
      end
    join
    repeat (3) @(negedge clk);
    chk("t6_ngrants", 64'(gnt_log.size()), 64'd2);
    if (gnt_log.size() > 0)
      chk("t6_first", 64'(gnt_log[0]), 64'h1);
    chk("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
